// File: rtl/frame_buf_scanout_reader_pkg.sv
// Geometry, address helper and tag layout shared by the frame-buffer writer and
// scanout reader.
package frame_buf_scanout_reader_pkg;
    localparam int VGA_WIDTH          = 640;
    localparam int VGA_HEIGHT         = 480;
    localparam int PIXEL_VIRTUAL_SIZE = 4;
    localparam int MEMORY_SIZE        = 19200;
    localparam int ADDR_W             = 15;
    localparam int RGB_W              = 24;
    localparam int COORD_W            = 10;
    localparam int VCOORD_W           = 8;

    typedef struct packed {
        logic fresh;
        logic in_range;
        logic hs;
        logic vs;
        logic active;
    } scan_tag_t;

    localparam int        TAG_W    = $bits(scan_tag_t);
    localparam scan_tag_t TAG_IDLE = '{fresh: 1'b0, in_range: 1'b0, hs: 1'b1, vs: 1'b1, active: 1'b0};

    // vy*160 + vx built from two shifts and an add; 119*160+159 = 19199 fits ADDR_W.
    function automatic logic [ADDR_W-1:0] virt_addr(input logic [VCOORD_W-1:0] vy,
                                                    input logic [VCOORD_W-1:0] vx);
        return (ADDR_W'(vy) << 7) + (ADDR_W'(vy) << 5) + ADDR_W'(vx);
    endfunction
endpackage

// File: rtl/scanout_delay_line.sv
// Parameterised-depth, parameterised-width shift register with async active-low
// reset to a caller-chosen idle value.
module scanout_delay_line #(
    parameter int               DEPTH     = 1,
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= RESET_VAL;
            end
        end else begin
            r_stage[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign q = r_stage[DEPTH-1];

endmodule

// File: rtl/frame_buf_scanout_reader.sv
// Maps 640x480 raster coordinates onto the 160x120 frame RAM with 4x4 replication,
// issues a read per new virtual pixel and realigns colour with the sync signals.
module frame_buf_scanout_reader
    import frame_buf_scanout_reader_pkg::*;
#(
    parameter int               RD_LATENCY = 2,
    parameter int               VIRT_W     = 160,
    parameter int               VIRT_H     = 120,
    parameter logic [RGB_W-1:0] BORDER_RGB = 24'h000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [COORD_W-1:0] x,
    input  logic [COORD_W-1:0] y,
    input  logic               active_in,
    input  logic               hs_in,
    input  logic               vs_in,
    output logic [ADDR_W-1:0]  rd_addr,
    output logic               rd_en,
    input  logic [RGB_W-1:0]   rd_data,
    output logic [RGB_W-1:0]   rgb_out,
    output logic               hs_out,
    output logic               vs_out,
    output logic               blank_n_out
);

    localparam int VSHIFT = $clog2(PIXEL_VIRTUAL_SIZE);

    logic [VCOORD_W-1:0] w_vx_p0;
    logic [VCOORD_W-1:0] w_vy_p0;
    logic [ADDR_W-1:0]   w_addr_p0;
    logic                w_in_range_p0;
    logic                w_issue_p0;
    logic                r_last_vld;
    logic [ADDR_W-1:0]   r_last_addr;
    scan_tag_t           r_tag_p0;
    scan_tag_t           w_tag_p1;
    logic [RGB_W-1:0]    r_hold_p2;
    logic                w_unused;

    assign w_vx_p0   = x[COORD_W-1:VSHIFT];
    assign w_vy_p0   = y[COORD_W-1:VSHIFT];
    assign w_addr_p0 = virt_addr(w_vy_p0, w_vx_p0);
    assign w_unused  = ^{x[VSHIFT-1:0], y[VSHIFT-1:0]};

    assign w_in_range_p0 = active_in
                        && (x < COORD_W'(VGA_WIDTH)) && (y < COORD_W'(VGA_HEIGHT))
                        && (w_vx_p0 < VCOORD_W'(VIRT_W)) && (w_vy_p0 < VCOORD_W'(VIRT_H));
    assign w_issue_p0 = w_in_range_p0 && (!r_last_vld || (w_addr_p0 != r_last_addr));

    // Stage p0: address, read strobe and tag registered together
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_addr     <= '0;
            rd_en       <= 1'b0;
            r_last_vld  <= 1'b0;
            r_last_addr <= '0;
            r_tag_p0    <= TAG_IDLE;
        end else begin
            rd_en    <= w_issue_p0;
            r_tag_p0 <= '{fresh: w_issue_p0, in_range: w_in_range_p0,
                          hs: hs_in, vs: vs_in, active: active_in};
            if (w_issue_p0) begin
                rd_addr <= w_addr_p0;
            end
            // Blanking forgets the last address so each line re-fetches its first pixel
            if (!active_in) begin
                r_last_vld <= 1'b0;
            end else if (w_issue_p0) begin
                r_last_vld  <= 1'b1;
                r_last_addr <= w_addr_p0;
            end
        end
    end

    // Stage p1: tag delayed to line up with rd_data
    scanout_delay_line #(
        .DEPTH     (RD_LATENCY),
        .WIDTH     (TAG_W),
        .RESET_VAL (TAG_IDLE)
    ) u_tag_delay (
        .clk (clk),
        .rst (rst),
        .d   (r_tag_p0),
        .q   (w_tag_p1)
    );

    // Stage p2: registered colour and syncs to the pins
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold_p2   <= '0;
            rgb_out     <= BORDER_RGB;
            hs_out      <= 1'b1;
            vs_out      <= 1'b1;
            blank_n_out <= 1'b0;
        end else begin
            hs_out      <= w_tag_p1.hs;
            vs_out      <= w_tag_p1.vs;
            blank_n_out <= w_tag_p1.active;
            if (w_tag_p1.fresh) begin
                r_hold_p2 <= rd_data;
                rgb_out   <= rd_data;
            end else if (w_tag_p1.in_range) begin
                rgb_out   <= r_hold_p2;
            end else begin
                rgb_out   <= BORDER_RGB;
            end
        end
    end

endmodule

// File: tb/tb_frame_buf_scanout_reader.sv
// Self-checking bench for frame_buf_scanout_reader: directed scenarios plus a
// randomised raster walk compared against a pixel-level reference model.
module tb_frame_buf_scanout_reader;
    localparam int          RDL     = 2;
    localparam int          LAT_OBS = RDL + 1;
    localparam logic [23:0] BORDER  = 24'h000000;
    localparam int          MAXS    = 4096;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        active_in, hs_in, vs_in;
    logic [14:0] rd_addr;
    logic        rd_en;
    logic [23:0] rd_data, rgb_out;
    logic        hs_out, vs_out, blank_n_out;

    frame_buf_scanout_reader #(
        .RD_LATENCY (RDL), .VIRT_W (160), .VIRT_H (120), .BORDER_RGB (BORDER)
    ) dut (
        .clk (clk), .rst (rst), .x (x), .y (y), .active_in (active_in),
        .hs_in (hs_in), .vs_in (vs_in), .rd_addr (rd_addr), .rd_en (rd_en),
        .rd_data (rd_data), .rgb_out (rgb_out), .hs_out (hs_out), .vs_out (vs_out),
        .blank_n_out (blank_n_out)
    );

    always #10 clk = ~clk;

    // Frame RAM: data appears RDL cycles after rd_en, random garbage otherwise
    logic [23:0] ram [19200];
    bit   [14:0] pipe_addr [RDL];
    bit          pipe_vld  [RDL];
    bit   [23:0] noise;

    always @(posedge clk) begin
        pipe_vld[0]  <= rd_en;
        pipe_addr[0] <= rd_addr;
        for (int i = 1; i < RDL; i++) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_addr[i] <= pipe_addr[i-1];
        end
        noise <= 24'($urandom);
    end
    assign rd_data = pipe_vld[RDL-1] ? ram[pipe_addr[RDL-1]] : noise;

    // Reference model: per input sample, what the pins must show once it emerges
    bit [23:0] s_rgb   [MAXS];
    bit [14:0] s_addr  [MAXS];
    bit        s_hs    [MAXS];
    bit        s_vs    [MAXS];
    bit        s_blank [MAXS];
    bit        s_rd    [MAXS];
    bit        s_rst   [MAXS];
    int        n_steps = 0;
    bit        m_last_vld = 1'b0;
    int        m_last_addr = 0;
    int        n_checks = 0;
    int        n_errors = 0;

    // Apply one input sample at a falling edge, record its expectations, and return
    // at the next falling edge (after the DUT has sampled it).
    task automatic step(input int sx, input int sy, input bit sa, input bit shs,
                        input bit svs, input bit srst);
        int n  = n_steps;
        int vx = sx / 4;
        int vy = sy / 4;
        bit ir = sa && (sx < 640) && (sy < 480) && (vx < 160) && (vy < 120);
        int a  = vy * 160 + vx;
        if (n >= MAXS) begin
            $display("FAIL step_budget: got %0d steps expected below %0d", n, MAXS);
            $fatal(1);
        end
        x = 10'(sx); y = 10'(sy); active_in = sa; hs_in = shs; vs_in = svs; rst = srst;
        s_rst[n]   = srst;
        s_addr[n]  = 15'(a);
        s_rgb[n]   = ir ? ram[a] : BORDER;
        s_hs[n]    = shs;
        s_vs[n]    = svs;
        s_blank[n] = sa;
        if (!srst) begin
            s_rd[n]    = 1'b0;
            m_last_vld = 1'b0;
        end else begin
            s_rd[n] = ir && (!m_last_vld || a != m_last_addr);
            if (!sa) m_last_vld = 1'b0;
            else if (s_rd[n]) begin
                m_last_vld  = 1'b1;
                m_last_addr = a;
            end
        end
        n_steps++;
        @(negedge clk);
    endtask

    // True when the sample now due at the pins was lost to a reset while in flight
    function automatic bit flushed(input int k);
        if (k - LAT_OBS < 0) return 1'b1;
        for (int j = k - LAT_OBS; j <= k; j++) if (!s_rst[j]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic test_reset();
        for (int i = 0; i < 6; i++) begin
            step($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom),
                 1'($urandom), 1'($urandom), 1'b0);
            n_checks++; if (rd_en !== 1'b0) begin n_errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
            n_checks++; if (rd_addr !== 15'd0) begin n_errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
            n_checks++; if (rgb_out !== BORDER) begin n_errors++; $display("FAIL reset_rgb: got %h expected %h", rgb_out, BORDER); end
            n_checks++; if (blank_n_out !== 1'b0) begin n_errors++; $display("FAIL reset_blank: got %b expected 0", blank_n_out); end
            n_checks++; if ({hs_out, vs_out} !== 2'b11) begin n_errors++; $display("FAIL reset_sync: got %b%b expected 11", hs_out, vs_out); end
        end
    endtask

    task automatic test_address_map();
        step(700, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(5, 9, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rd_en !== 1'b1 || rd_addr !== 15'd321) begin n_errors++; $display("FAIL addr_map_321: got en=%b addr=%0d expected en=1 addr=321", rd_en, rd_addr); end
        for (int i = 0; i < 3; i++) begin
            step(5, 9, 1'b1, 1'b1, 1'b1, 1'b1);
            n_checks++; if (rd_en !== 1'b0) begin n_errors++; $display("FAIL addr_map_held: got %b expected 0", rd_en); end
        end
        step(639, 479, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rd_en !== 1'b1 || rd_addr !== 15'd19199) begin n_errors++; $display("FAIL addr_map_max: got en=%b addr=%0d expected en=1 addr=19199", rd_en, rd_addr); end
        for (int i = 0; i < LAT_OBS; i++) step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rgb_out !== ram[19199] || blank_n_out !== 1'b1) begin n_errors++; $display("FAIL addr_map_max_rgb: got %h/%b expected %h/1", rgb_out, blank_n_out, ram[19199]); end
    endtask

    task automatic test_read_suppression();
        int          pulses = 0;
        logic [14:0] paddr[$];
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 16 + LAT_OBS; i++) begin
            if (i < 16) begin
                step(i / 2, 0, 1'b1, 1'b1, 1'b1, 1'b1);
                if (rd_en === 1'b1) begin pulses++; paddr.push_back(rd_addr); end
            end else begin
                step(8, 0, 1'b0, 1'b1, 1'b1, 1'b1);
            end
            if (i >= LAT_OBS && i - LAT_OBS < 16) begin
                logic [23:0] e;
                e = (i - LAT_OBS < 8) ? ram[0] : ram[1];
                n_checks++; if (rgb_out !== e) begin n_errors++; $display("FAIL suppress_rgb[%0d]: got %h expected %h", i - LAT_OBS, rgb_out, e); end
            end
        end
        n_checks++; if (pulses != 2) begin n_errors++; $display("FAIL suppress_pulses: got %0d expected 2", pulses); end
        if (paddr.size() == 2) begin
            n_checks++; if (paddr[0] !== 15'd0 || paddr[1] !== 15'd1) begin n_errors++; $display("FAIL suppress_addrs: got %0d,%0d expected 0,1", paddr[0], paddr[1]); end
        end
    endtask

    task automatic test_latency_align();
        ram[0] = 24'hFF8000;
        for (int i = 0; i < 3; i++) step(700, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 1; i <= 4; i++) begin
            if (i == 1) step(0, 0, 1'b1, 1'b0, 1'b1, 1'b1);
            else        step(i - 1, 0, 1'b1, 1'b1, 1'b1, 1'b1);
            if (i == 3) begin
                n_checks++; if (rgb_out !== BORDER || hs_out !== 1'b1) begin n_errors++; $display("FAIL latency_early: got rgb=%h hs=%b expected rgb=%h hs=1", rgb_out, hs_out, BORDER); end
            end
            if (i == 4) begin
                n_checks++; if (rgb_out !== 24'hFF8000) begin n_errors++; $display("FAIL latency_rgb: got %h expected ff8000", rgb_out); end
                n_checks++; if (hs_out !== 1'b0 || blank_n_out !== 1'b1) begin n_errors++; $display("FAIL latency_sync: got hs=%b blank_n=%b expected hs=0 blank_n=1", hs_out, blank_n_out); end
            end
        end
    endtask

    task automatic test_blanking();
        for (int i = 0; i < 4; i++) begin
            step(700, 3, 1'b0, 1'b1, 1'b1, 1'b1);
            n_checks++; if (rd_en !== 1'b0) begin n_errors++; $display("FAIL blank_no_read: got %b expected 0", rd_en); end
        end
        n_checks++; if (rgb_out !== BORDER || blank_n_out !== 1'b0) begin n_errors++; $display("FAIL blank_rgb: got %h/%b expected %h/0", rgb_out, blank_n_out, BORDER); end
        step(0, 4, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rd_en !== 1'b1 || rd_addr !== 15'd160) begin n_errors++; $display("FAIL blank_line_start: got en=%b addr=%0d expected en=1 addr=160", rd_en, rd_addr); end
        step(700, 10, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rd_en !== 1'b0) begin n_errors++; $display("FAIL oor_x_read: got %b expected 0", rd_en); end
        step(100, 500, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rd_en !== 1'b0) begin n_errors++; $display("FAIL oor_y_read: got %b expected 0", rd_en); end
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rgb_out !== BORDER || blank_n_out !== 1'b1) begin n_errors++; $display("FAIL oor_x_rgb: got %h/%b expected %h/1", rgb_out, blank_n_out, BORDER); end
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rgb_out !== BORDER || blank_n_out !== 1'b1) begin n_errors++; $display("FAIL oor_y_rgb: got %h/%b expected %h/1", rgb_out, blank_n_out, BORDER); end
    endtask

    task automatic test_mid_frame_reset();
        step(0, 0, 1'b0, 1'b1, 1'b1, 1'b1);
        step(80, 12, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rd_en !== 1'b1 || rd_addr !== 15'd500) begin n_errors++; $display("FAIL mfr_pre_read: got en=%b addr=%0d expected en=1 addr=500", rd_en, rd_addr); end
        step(80, 12, 1'b1, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            step(80, 12, 1'b1, 1'b1, 1'b1, 1'b0);
            n_checks++; if (rgb_out !== BORDER || rd_en !== 1'b0 || blank_n_out !== 1'b0) begin n_errors++; $display("FAIL mfr_in_reset: got rgb=%h en=%b blank_n=%b expected %h/0/0", rgb_out, rd_en, blank_n_out, BORDER); end
        end
        step(80, 12, 1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++; if (rd_en !== 1'b1 || rd_addr !== 15'd500) begin n_errors++; $display("FAIL mfr_reread: got en=%b addr=%0d expected en=1 addr=500", rd_en, rd_addr); end
        for (int i = 1; i <= LAT_OBS; i++) begin
            step(80, 12, 1'b1, 1'b1, 1'b1, 1'b1);
            if (i < LAT_OBS) begin
                n_checks++; if (rgb_out !== BORDER || blank_n_out !== 1'b0) begin n_errors++; $display("FAIL mfr_stale[%0d]: got %h/%b expected %h/0", i, rgb_out, blank_n_out, BORDER); end
            end else begin
                n_checks++; if (rgb_out !== ram[500] || blank_n_out !== 1'b1) begin n_errors++; $display("FAIL mfr_first_rgb: got %h/%b expected %h/1", rgb_out, blank_n_out, ram[500]); end
            end
        end
    endtask

    task automatic test_random_raster();
        int cx = 0;
        int cy = 0;
        for (int i = 0; i < 2000; i++) begin
            int r = $urandom_range(0, 99);
            bit act, srst;
            int k, s;
            if (r >= 55 && r < 88) begin
                cx++;
                if (cx >= 800) begin cx = 0; cy = (cy + 1) % 525; end
            end else if (r >= 88) begin
                cx = $urandom_range(0, 799);
                cy = $urandom_range(0, 524);
            end
            act  = (cx < 640 && cy < 480) || ($urandom_range(0, 19) == 0);
            srst = ($urandom_range(0, 149) != 0);
            step(cx, cy, act, !(cx >= 656 && cx < 752), !(cy >= 490 && cy < 492), srst);
            k = n_steps - 1;
            s = k - LAT_OBS;
            n_checks++; if (rd_en !== s_rd[k]) begin n_errors++; $display("FAIL rand_rd_en[%0d]: got %b expected %b", k, rd_en, s_rd[k]); end
            if (s_rd[k]) begin
                n_checks++; if (rd_addr !== s_addr[k]) begin n_errors++; $display("FAIL rand_rd_addr[%0d]: got %0d expected %0d", k, rd_addr, s_addr[k]); end
            end
            if (flushed(k)) begin
                n_checks++; if ({rgb_out, hs_out, vs_out, blank_n_out} !== {BORDER, 3'b110}) begin n_errors++; $display("FAIL rand_flushed[%0d]: got %h %b%b%b expected %h 110", k, rgb_out, hs_out, vs_out, blank_n_out, BORDER); end
            end else begin
                n_checks++; if (rgb_out !== s_rgb[s]) begin n_errors++; $display("FAIL rand_rgb[%0d]: got %h expected %h", k, rgb_out, s_rgb[s]); end
                n_checks++; if ({hs_out, vs_out, blank_n_out} !== {s_hs[s], s_vs[s], s_blank[s]}) begin n_errors++; $display("FAIL rand_sync[%0d]: got %b%b%b expected %b%b%b", k, hs_out, vs_out, blank_n_out, s_hs[s], s_vs[s], s_blank[s]); end
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 19200; i++) ram[i] = 24'($urandom);
        rst = 1'b0; x = '0; y = '0; active_in = 1'b0; hs_in = 1'b1; vs_in = 1'b1;
        @(negedge clk);
        test_reset();
        test_address_map();
        test_read_suppression();
        test_latency_align();
        test_blanking();
        test_mid_frame_reset();
        test_random_raster();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/frame_buf_scanout_reader.md
Name: frame_buf_scanout_reader

Overview:
- Read-side counterpart of the frame-buffer pixel writer.
- Converts VGA raster coordinates (640x480) into 160x120 virtual frame-buffer read addresses, with 4x4 pixel replication.
- Issues reads only when the virtual address changes, absorbs the RAM read latency, and presents registered RGB plus delay-matched sync/blank to the VGA pins.
- Sits between vga_frame_driver's x/y/active outputs and the frame RAM read port.

Parameters:
- RD_LATENCY, 2, RAM read latency in clk cycles from rd_en to valid rd_data (1..4).
- VIRT_W, 160, virtual pixel columns.
- VIRT_H, 120, virtual pixel rows.
- BORDER_RGB, 24'h000000, colour driven when inactive or out of range.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  asynchronous, active-low reset.
- x  in  10  current raster column.
- y  in  10  current raster row.
- active_in  in  1  raster is in visible area.
- hs_in  in  1  horizontal sync from timing generator.
- vs_in  in  1  vertical sync from timing generator.
- rd_addr  out  15  frame RAM read address.
- rd_en  out  1  read strobe, one cycle per issued read.
- rd_data  in  24  RAM read data, valid RD_LATENCY cycles after rd_en.
- rgb_out  out  24  {R,G,B} to VGA DAC.
- hs_out  out  1  hs_in delayed to match rgb_out.
- vs_out  out  1  vs_in delayed to match rgb_out.
- blank_n_out  out  1  active-high visible flag, delayed to match rgb_out.

Behaviour:
- Reset (async, rst=0): rd_addr=0, rd_en=0, rgb_out=BORDER_RGB, hs_out=1, vs_out=1, blank_n_out=0. All pipeline valid/tag bits and the hold register are cleared. last_addr is invalidated.
- Address calculation (stage 0, registered):
  - vx = x>>2, vy = y>>2.
  - addr = vy*160 + vx, computed as (vy<<7)+(vy<<5)+vx, 15-bit result. No multiplier.
- in_range = active_in && vx<VIRT_W && vy<VIRT_H.
- Read issue: rd_en=1 for one cycle when in_range and (addr != last_addr or last_addr invalid). last_addr is then updated.
- last_addr is invalidated when active_in=0, so every new line re-reads its first pixel.
- Tag pipeline: a RD_LATENCY+1 deep shift register carries {fresh, in_range, hs, vs, active}. fresh equals rd_en of the same stage.
- Output stage:
  - If tag.fresh: hold_reg <= rd_data and rgb_out <= rd_data.
  - Else if tag.in_range: rgb_out <= hold_reg.
  - Else: rgb_out <= BORDER_RGB.
- Total latency from x/y/active/hs/vs sampled to rgb_out/hs_out/vs_out/blank_n_out = RD_LATENCY+2 cycles (4 by default). Sync outputs and colour must be exactly aligned.
- Repeated inputs: x/y held for several clk (pixel-clock divide) produce a single read.
- Boundaries:
  - x=639 to 0 wrap: active drops, so no read is issued.
  - Address 19199 (vx=159, vy=119) is the maximum and must never overflow.
  - x>=640 or y>=480 with active_in erroneously high: in_range=0, BORDER_RGB, no read.
- Reset mid-frame: pipeline is flushed immediately. The first read after release occurs on the first in_range cycle.
- rd_data is ignored except on the fresh tag cycle.

Decomposition:
- Shared package: VGA_WIDTH=640, VGA_HEIGHT=480, PIXEL_VIRTUAL_SIZE=4, MEMORY_SIZE=19200, ADDR_W=15, RGB_W=24. The writer side already uses these values, so both sides share one source.
- One natural sub-module: scanout_delay_line, a parameterised-depth, parameterised-width shift register with async active-low reset. It is used for the tag/sync pipeline.

Test Plan:
- Reset: hold rst=0 with random inputs -> rd_en=0, rgb_out=0, blank_n_out=0, hs_out=vs_out=1.
- Address map: x=5, y=9, active=1 -> rd_addr=2*160+1=321 with rd_en pulsed once. x=639, y=479 -> rd_addr=19199.
- Read suppression: sweep x=0..7 at y=0, each held 2 clk -> exactly 2 rd_en pulses (addr 0, 1). rgb_out repeats RAM[0] for 8 pixel periods, then RAM[1].
- Latency/alignment: RAM model with RD_LATENCY=2, RAM[0]=24'hFF8000, hs pulse injected with the first pixel -> rgb_out=FF8000 and the hs_out edge both appear 4 cycles later.
- Blanking: active_in=0 with x=700 -> rgb_out=BORDER_RGB, no rd_en. Next line start (x=0, y=4) -> fresh read of addr 160.
- Mid-frame reset: assert rst during active line at addr 500, release -> no stale rgb_out. The first output after release comes from a new rd_en.
